// File: rtl/rv_skid_pkg.sv
// rv_skid_pkg: shared defaults and pointer-width helper for the rv_skid_fifo slice.
package rv_skid_pkg;
  localparam int SKID_WIDTH_DEF = 34;
  localparam int SKID_DEPTH_DEF = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/rv_skid_fifo_if.sv
// rv_skid_fifo_if: producer/consumer handshake bundle; parity pins exist only with RV_SKID_PAR_EN.
interface rv_skid_fifo_if
  import rv_skid_pkg::*;
#(
  parameter int WIDTH = SKID_WIDTH_DEF,
  parameter int DEPTH = SKID_DEPTH_DEF
);
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [ptr_w(DEPTH):0] count;
`ifdef RV_SKID_PAR_EN
  logic in_par, par_err;
  modport master (output flush, in_valid, in_data, out_ready, in_par,
                  input in_ready, out_valid, out_data, count, par_err);
  modport slave (input flush, in_valid, in_data, out_ready, in_par,
                 output in_ready, out_valid, out_data, count, par_err);
`else
  modport master (output flush, in_valid, in_data, out_ready,
                  input in_ready, out_valid, out_data, count);
  modport slave (input flush, in_valid, in_data, out_ready,
                 output in_ready, out_valid, out_data, count);
`endif
endinterface

// File: rtl/rv_skid_entry.sv
// rv_skid_entry: one storage word with write enable and async reset to zero.
module rv_skid_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/rv_skid_fifo.sv
// rv_skid_fifo: valid/ready elastic buffer, no bypass; RV_SKID_PAR_EN adds per-entry parity check.
module rv_skid_fifo
  import rv_skid_pkg::*;
#(
  parameter int WIDTH = SKID_WIDTH_DEF,
  parameter int DEPTH = SKID_DEPTH_DEF
) (
  input logic clk,
  input logic rst,
  rv_skid_fifo_if.slave bus
);
  localparam int PW = ptr_w(DEPTH);
`ifdef RV_SKID_PAR_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic [EW-1:0] q [DEPTH];
  logic [EW-1:0] din, head;
  logic push, pop;
`ifdef RV_SKID_PAR_EN
  assign din = {bus.in_par, bus.in_data};
`else
  assign din = bus.in_data;
`endif
  assign head          = q[rd_ptr];
  assign bus.in_ready  = (cnt != (PW+1)'(DEPTH)) & ~bus.flush;
  assign bus.out_valid = cnt != '0;
  assign bus.out_data  = head[WIDTH-1:0];
  assign bus.count     = cnt;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    rv_skid_entry #(.W(EW)) u_entry (
      .clk(clk),
      .rst(rst),
      .we (push & (wr_ptr == PW'(g))),
      .d  (din),
      .q  (q[g])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
`ifdef RV_SKID_PAR_EN
  // a pop discarded by flush never flags an error
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.par_err <= 1'b0;
    else bus.par_err <= pop & ~bus.flush & ((^head[WIDTH-1:0]) != head[WIDTH]);
`endif
endmodule

// File: tb/tb_rv_skid_fifo.sv
// tb_rv_skid_fifo: directed scoreboard bench for rv_skid_fifo (RV_SKID_PAR_EN adds parity steps).
module tb_rv_skid_fifo;
  typedef struct {
    logic [33:0] d;
    logic        p;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pbad = 1'b0;
  logic exp_pe = 1'b0;
  logic last_push = 1'b0;
  int vecs = 0;
  int fails = 0;
  ent_t sb[$];
  rv_skid_fifo_if #(.WIDTH(34), .DEPTH(4)) bus ();
  rv_skid_fifo #(.WIDTH(34), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic iv, input logic [33:0] d, input logic orr, input logic fl);
    ent_t e;
    logic m_rdy, m_pop, m_push;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = orr;
    bus.flush     = fl;
`ifdef RV_SKID_PAR_EN
    bus.in_par = (^d) ^ pbad;
`endif
    #3;
    m_rdy  = (sb.size() != 4) && !fl;
    m_push = iv && m_rdy;
    m_pop  = (sb.size() != 0) && orr;
    chk("count", bus.count, sb.size());
    chk("in_ready", bus.in_ready, m_rdy);
    chk("out_valid", bus.out_valid, sb.size() != 0);
    if (m_pop) chk("out_data", bus.out_data, sb[0].d);
`ifdef RV_SKID_PAR_EN
    chk("par_err", bus.par_err, exp_pe);
`endif
    exp_pe = 1'b0;
    if (fl) sb.delete();
    else begin
      if (m_pop) begin
        e = sb.pop_front();
        exp_pe = e.p != (^e.d);
      end
      if (m_push) sb.push_back('{d, (^d) ^ pbad});
    end
    last_push = m_push && !fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int k;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0; bus.flush = 0;
`ifdef RV_SKID_PAR_EN
    bus.in_par = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_out_data", bus.out_data, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 34'(i), 0, 0);
    cyc(1, 34'd5, 0, 0);
    cyc(1, 34'd5, 1, 0);
    cyc(1, 34'd5, 1, 0);
    repeat (4) cyc(0, 0, 1, 0);
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      cyc(1, k[0] ? 34'h1_5555_5555 : 34'h2_AAAA_AAAA, 1'($urandom_range(0, 1)), 0);
      if (last_push) k++;
    end
    chk("wrap_pushes", k, 10);
    for (int c = 0; c < 8 && sb.size() != 0; c++) cyc(0, 0, 1, 0);
    chk("wrap_drained", bus.count, 0);
    cyc(1, 34'h0_1234_5678, 0, 0);
    cyc(1, 34'h1_8765_4321, 0, 0);
    cyc(1, 34'h3_FFFF_FFFF, 1, 0);
    repeat (3) cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 34'h2_0000_0000 + 34'(i), 0, 0);
    cyc(1, 34'h0_DEAD_BEEF, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 34'h0_0000_00AA, 0, 0);
    cyc(0, 0, 1, 0);
`ifdef RV_SKID_PAR_EN
    pbad = 1;
    cyc(1, 34'h0_0000_0001, 0, 0);
    pbad = 0;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 34'h0_0000_0001, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
`endif
    for (int i = 0; i < 3; i++) cyc(1, 34'h1_0000_0010 + 34'(i), 0, 0);
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
    rst = 1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_in_ready", bus.in_ready, 1);
`ifdef RV_SKID_PAR_EN
    chk("arst_par_err", bus.par_err, 0);
`endif
    sb.delete();
    exp_pe = 0;
    @(posedge clk);
    #1;
    rst = 0;
    cyc(1, 34'h0_0000_0077, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
